// File: rtl/npc_fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npc_fetch_ctrl_if                                                    |
// | Single-outstanding instruction-memory request/ack bus.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface npc_fetch_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/npc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npc_fetch_ctrl                                                       |
// | PC/NPC sequencing, imem fetch handshake, one-entry ID buffer and     |
// | delay-slot redirects. Optional macro: NPC_EXC_REDIRECT_EN.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module npc_fetch_ctrl #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] PC_INIT = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic              pc_en,
   npc_fetch_ctrl_if.master  imem,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
`ifdef NPC_EXC_REDIRECT_EN
   input  logic              exc_valid,
   input  logic [ADDR_W-1:0] exc_target,
`endif
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              id_stall
);

`ifdef NPC_EXC_REDIRECT_EN
   typedef enum logic [1:0] {S_INIT = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_INIT = 2'd0, S_FETCH = 2'd1} state_t;
`endif

   state_t            r_state;
   logic              r_busy;
   logic              r_pend;
   logic [ADDR_W-1:0] r_pend_target;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;
`ifdef NPC_EXC_REDIRECT_EN
   logic [ADDR_W-1:0] r_exc_target;
   logic              w_exc_fire;
`endif

   logic              w_req;
   logic              w_ack;
   logic              w_fill;
   logic [ADDR_W-1:0] w_sel;

   always_comb begin
      w_req  = 1'b0;
      w_sel  = pc + ADDR_W'(4);
`ifdef NPC_EXC_REDIRECT_EN
      w_exc_fire = 1'b0;
`endif
      if (redirect_valid)
         w_sel = redirect_target;
      else if (r_pend)
         w_sel = r_pend_target;

      // r_busy keeps a raised request up until its ack even if ID stalls.
      if (!reset) begin
         case (r_state)
            S_FETCH: w_req = r_busy || !r_instr_valid || !id_stall;
`ifdef NPC_EXC_REDIRECT_EN
            S_DRAIN: w_req = r_busy;
`endif
            default: w_req = 1'b0;
         endcase
`ifdef NPC_EXC_REDIRECT_EN
         // An idle exception redirects at once, so no new fetch may start.
         if (r_state == S_FETCH && exc_valid && !r_busy)
            w_req = 1'b0;
`endif
      end

      w_ack  = w_req && imem.imem_ack;
      w_fill = w_ack;
      pc_en  = w_ack;

`ifdef NPC_EXC_REDIRECT_EN
      if (!reset && r_state == S_FETCH && exc_valid) begin
         w_fill = 1'b0;
         if (!r_busy || w_ack) begin
            w_exc_fire = 1'b1;
            w_sel      = exc_target;
         end
      end
      if (!reset && r_state == S_DRAIN && w_ack) begin
         w_exc_fire = 1'b1;
         w_sel      = exc_valid ? exc_target : r_exc_target;
      end
      if (w_exc_fire)
         pc_en = 1'b1;
`endif

      npc = w_sel & ~ADDR_W'(3);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_INIT;
         r_busy        <= 1'b0;
         r_pend        <= 1'b0;
         r_pend_target <= '0;
         r_instr       <= '0;
         r_instr_pc    <= PC_INIT;
         r_instr_valid <= 1'b0;
`ifdef NPC_EXC_REDIRECT_EN
         r_exc_target  <= '0;
`endif
      end else begin
         r_busy <= w_req && !w_ack;
         case (r_state)
            S_INIT: r_state <= S_FETCH;
            S_FETCH: begin
               if (w_fill) begin
                  r_instr       <= imem.imem_rdata;
                  r_instr_pc    <= pc;
                  r_instr_valid <= 1'b1;
               end else if (r_instr_valid && !id_stall) begin
                  r_instr_valid <= 1'b0;
               end
               // The in-flight fetch is the delay slot; the target waits for its ack.
               if (redirect_valid && !w_ack) begin
                  r_pend        <= 1'b1;
                  r_pend_target <= redirect_target;
               end else if (w_ack) begin
                  r_pend <= 1'b0;
               end
`ifdef NPC_EXC_REDIRECT_EN
               if (exc_valid) begin
                  r_pend        <= 1'b0;
                  r_instr_valid <= 1'b0;
                  if (!w_exc_fire) begin
                     r_state      <= S_DRAIN;
                     r_exc_target <= exc_target;
                  end
               end
`endif
            end
`ifdef NPC_EXC_REDIRECT_EN
            S_DRAIN: begin
               r_pend        <= 1'b0;
               r_instr_valid <= 1'b0;
               if (exc_valid)
                  r_exc_target <= exc_target;
               if (w_ack)
                  r_state <= S_FETCH;
            end
`endif
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = pc;
   assign instr          = r_instr;
   assign instr_pc       = r_instr_pc;
   assign instr_valid    = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_npc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_npc_fetch_ctrl                                                    |
// | Directed bench with PC register and variable-latency imem model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_npc_fetch_ctrl;
   localparam int          ADDR_W    = 32;
   localparam logic [31:0] C_PC_INIT = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        pc_en;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        id_stall;
`ifdef NPC_EXC_REDIRECT_EN
   logic        exc_valid;
   logic [31:0] exc_target;
`endif

   logic        pc_force;
   logic [31:0] pc_force_val;
   int          lat;
   int          wcnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   npc_fetch_ctrl_if #(.ADDR_W(ADDR_W)) imem ();

   npc_fetch_ctrl #(
      .ADDR_W  (ADDR_W),
      .PC_INIT (C_PC_INIT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .npc             (npc),
      .pc_en           (pc_en),
      .imem            (imem.master),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
`ifdef NPC_EXC_REDIRECT_EN
      .exc_valid       (exc_valid),
      .exc_target      (exc_target),
`endif
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .id_stall        (id_stall)
   );

   // Memory acks in the lat-th cycle of a request; lat=1 is zero-wait.
   assign imem.imem_ack   = imem.imem_req && (wcnt >= lat - 1);
   assign imem.imem_rdata = {16'hA5A5, imem.imem_addr[15:0]};

   always @(posedge clk) begin
      if (!imem.imem_req || imem.imem_ack) wcnt <= 0;
      else                                 wcnt <= wcnt + 1;
   end

   always @(posedge clk) begin
      if (reset)         pc <= C_PC_INIT;
      else if (pc_force) pc <= pc_force_val;
      else if (pc_en)    pc <= npc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=%0d expected=0", 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      pc_force = 1'b0; pc_force_val = '0; lat = 1;
`ifdef NPC_EXC_REDIRECT_EN
      exc_valid = 1'b0; exc_target = '0;
`endif
      tick(); tick(); #1;
      check("rst_req",      32'(imem.imem_req), 32'd0);
      check("rst_pc_en",    32'(pc_en),         32'd0);
      check("rst_valid",    32'(instr_valid),   32'd0);
      check("rst_instr",    instr,              32'h0);
      check("rst_instr_pc", instr_pc,           32'h0000_3000);
      check("rst_npc",      npc,                32'h0000_3004);
      reset = 1'b0; #1;
      check("init_req",   32'(imem.imem_req), 32'd0);
      check("init_pc_en", 32'(pc_en),         32'd0);

      // zero-wait streaming
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         check("seq_pc_en", 32'(pc_en), 32'd1);
         check("seq_addr",  imem.imem_addr, 32'h3000 + 32'(4 * k));
         if (k > 0) check("seq_instr_pc", instr_pc, 32'h3000 + 32'(4 * (k - 1)));
      end

      // 3-cycle latency at 0x3010
      tick(); lat = 3; #1;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin tick(); #1; end
         check("lat_req",   32'(imem.imem_req), 32'd1);
         check("lat_addr",  imem.imem_addr,     32'h3010);
         check("lat_pc_en", 32'(pc_en),         32'(c == 2));
      end
      check("lat_npc", npc, 32'h3014);

      // ID stall with a full buffer
      tick(); lat = 1; id_stall = 1'b1; #1;
      check("lat_instr_pc", instr_pc, 32'h3010);
      for (int s = 0; s < 4; s++) begin
         if (s > 0) begin tick(); #1; end
         check("stall_req",   32'(imem.imem_req), 32'd0);
         check("stall_instr", instr,              32'hA5A5_3010);
         check("stall_pc_en", 32'(pc_en),         32'd0);
      end
      tick(); id_stall = 1'b0; #1;
      check("rel_req",      32'(imem.imem_req), 32'd1);
      check("rel_addr",     imem.imem_addr,     32'h3014);
      check("rel_hold_pc",  instr_pc,           32'h3010);
      tick(); #1;
      check("rel_instr_pc", instr_pc, 32'h3014);
      check("rel_instr",    instr,    32'hA5A5_3014);

      // redirect two cycles before the ack of 0x3020
      tick(); tick(); lat = 3; redirect_valid = 1'b1; redirect_target = 32'h3100; #1;
      check("rd_addr",  imem.imem_addr, 32'h3020);
      check("rd_pc_en", 32'(pc_en),     32'd0);
      check("rd_npc",   npc,            32'h3100);
      tick(); redirect_valid = 1'b0; #1;
      check("rd_pend_npc",   npc,        32'h3100);
      check("rd_pend_pc_en", 32'(pc_en), 32'd0);
      tick(); #1;
      check("rd_ack_pc_en", 32'(pc_en),     32'd1);
      check("rd_ack_addr",  imem.imem_addr, 32'h3020);
      check("rd_ack_npc",   npc,            32'h3100);
      tick(); lat = 1; #1;
      check("ds_instr_pc", instr_pc,       32'h3020);
      check("ds_addr",     imem.imem_addr, 32'h3100);
      check("ds_npc",      npc,            32'h3104);
      tick(); #1;
      check("tgt_instr_pc", instr_pc, 32'h3100);

      // wrap and alignment
      pc_force = 1'b1; pc_force_val = 32'hFFFF_FFFC;
      tick(); pc_force = 1'b0; #1;
      check("wrap_addr",  imem.imem_addr, 32'hFFFF_FFFC);
      check("wrap_npc",   npc,            32'h0000_0000);
      check("wrap_pc_en", 32'(pc_en),     32'd1);
      redirect_valid = 1'b1; redirect_target = 32'h3103; #1;
      check("align_npc", npc, 32'h3100);
      tick(); redirect_valid = 1'b0; lat = 3; #1;
      check("wrap_instr",      instr,          32'hA5A5_FFFC);
      check("wrap_instr_pc",   instr_pc,       32'hFFFF_FFFC);
      check("align_addr",      imem.imem_addr, 32'h3100);
      check("align_npc_after", npc,            32'h3104);

      // reset while a fetch is outstanding
      tick(); reset = 1'b1; #1;
      check("rstb_req",   32'(imem.imem_req), 32'd0);
      check("rstb_pc_en", 32'(pc_en),         32'd0);
      tick(); reset = 1'b0; #1;
      check("rstb_init_req", 32'(imem.imem_req), 32'd0);
      check("rstb_valid",    32'(instr_valid),   32'd0);
      check("rstb_instr_pc", instr_pc,           32'h3000);
      check("rstb_npc",      npc,                32'h3004);
      tick(); #1;
      check("rstb_fetch_req",   32'(imem.imem_req), 32'd1);
      check("rstb_fetch_addr",  imem.imem_addr,     32'h3000);
      check("rstb_fetch_pc_en", 32'(pc_en),         32'd0);

`ifdef NPC_EXC_REDIRECT_EN
      // exception during an outstanding fetch
      tick(); exc_valid = 1'b1; exc_target = 32'h4180; #1;
      check("exc_req",   32'(imem.imem_req), 32'd1);
      check("exc_pc_en", 32'(pc_en),         32'd0);
      tick(); exc_valid = 1'b0; #1;
      check("drain_req",   32'(imem.imem_req), 32'd1);
      check("drain_addr",  imem.imem_addr,     32'h3000);
      check("drain_pc_en", 32'(pc_en),         32'd1);
      check("drain_npc",   npc,                32'h4180);
      tick(); #1;
      check("drain_valid", 32'(instr_valid),   32'd0);
      check("exc_addr",    imem.imem_addr,     32'h4180);
      check("exc_req2",    32'(imem.imem_req), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
